// File: rtl/stack_alu_unit.sv
// Stack-machine ALU: pops one or two operands from an external LIFO,
// applies one of eight operations, pushes the result and reports Z/S/C/V.
module stack_alu_unit #(
  parameter int DATA_LEN = 8,
  parameter int CNT_W    = 4
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic                start,
  input  logic [2:0]          opcode,
  output logic                busy,
  output logic                done,
  output logic                err,
  output logic                z_flag,
  output logic                s_flag,
  output logic                c_flag,
  output logic                v_flag,
  input  logic [CNT_W-1:0]    stk_count,
  input  logic [DATA_LEN-1:0] stk_data_out,
  output logic                stk_pop,
  output logic                stk_push,
  output logic [DATA_LEN-1:0] stk_data_in
);

  localparam int M = DATA_LEN - 1;

  typedef enum logic [2:0] {
    IDLE, POP1, CAP1, POP2, CAP2, EXEC, PUSH, DONE
  } state_t;

  typedef enum logic [2:0] {
    OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_NEG, OP_SHL, OP_SAR
  } op_t;

  state_t              state, state_n;
  op_t                 op_q, op_n;
  logic [DATA_LEN-1:0] op1, op1_n, op2, op2_n, res, res_n;
  logic                res_c, res_c_n, res_v, res_v_n;
  logic                busy_n, done_n, err_n, pop_n, push_n;
  logic                z_n, s_n, c_n, v_n;
  logic [DATA_LEN-1:0] data_in_n;

  logic [DATA_LEN-1:0] alu_res;
  logic [DATA_LEN:0]   sum_w;
  logic                alu_c, alu_v;
  logic [CNT_W-1:0]    need;

  // Operand order: op1 is the former top of stack, op2 the entry beneath it.
  always_comb begin
    // NOTE: every variable gets a default first so no path through the case infers a latch.
    alu_res = '0;
    alu_c   = 1'b0;
    alu_v   = 1'b0;
    sum_w   = '0;
    unique case (op_q)
      OP_ADD: begin
        sum_w   = {1'b0, op2} + {1'b0, op1};
        alu_res = sum_w[M:0];
        alu_c   = sum_w[DATA_LEN];
        alu_v   = (op2[M] == op1[M]) && (alu_res[M] != op2[M]);
      end
      OP_SUB: begin
        alu_res = op2 - op1;
        alu_c   = op2 < op1;
        alu_v   = (op2[M] != op1[M]) && (alu_res[M] != op2[M]);
      end
      OP_AND: alu_res = op2 & op1;
      OP_OR:  alu_res = op2 | op1;
      OP_XOR: alu_res = op2 ^ op1;
      OP_NEG: begin
        alu_res = '0 - op1;
        alu_c   = |op1;
        alu_v   = op1 == {1'b1, {M{1'b0}}};
      end
      OP_SHL: begin
        alu_res = {op1[M-1:0], 1'b0};
        alu_c   = op1[M];
        alu_v   = op1[M] ^ op1[M-1];
      end
      OP_SAR: begin
        alu_res = {op1[M], op1[M:1]};
        alu_c   = op1[0];
      end
      default: ;
    endcase
  end

  // Underflow is judged against the incoming opcode before anything is popped.
  assign need = (opcode >= 3'(OP_NEG)) ? CNT_W'(1) : CNT_W'(2);

  always_comb begin
    state_n   = state;
    op_n      = op_q;
    op1_n     = op1;
    op2_n     = op2;
    res_n     = res;
    res_c_n   = res_c;
    res_v_n   = res_v;
    busy_n    = busy;
    done_n    = 1'b0;
    err_n     = err;
    pop_n     = 1'b0;
    push_n    = 1'b0;
    data_in_n = stk_data_in;
    z_n       = z_flag;
    s_n       = s_flag;
    c_n       = c_flag;
    v_n       = v_flag;
    unique case (state)
      IDLE: if (start) begin
        op_n   = op_t'(opcode);
        busy_n = 1'b1;
        err_n  = 1'b0;
        if (stk_count < need) begin
          state_n = DONE;
          err_n   = 1'b1;
          done_n  = 1'b1;
        end else begin
          state_n = POP1;
          pop_n   = 1'b1;
        end
      end
      POP1: state_n = CAP1;
      CAP1: begin
        op1_n = stk_data_out;
        if (op_q >= OP_NEG) begin
          state_n = EXEC;
        end else begin
          state_n = POP2;
          pop_n   = 1'b1;
        end
      end
      POP2: state_n = CAP2;
      CAP2: begin
        op2_n   = stk_data_out;
        state_n = EXEC;
      end
      EXEC: begin
        res_n     = alu_res;
        res_c_n   = alu_c;
        res_v_n   = alu_v;
        data_in_n = alu_res;
        push_n    = 1'b1;
        state_n   = PUSH;
      end
      PUSH: begin
        z_n     = (res == '0);
        s_n     = res[M];
        c_n     = res_c;
        v_n     = res_v;
        done_n  = 1'b1;
        state_n = DONE;
      end
      DONE: begin
        busy_n  = 1'b0;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state       <= IDLE;
      op_q        <= OP_ADD;
      op1         <= '0;
      op2         <= '0;
      res         <= '0;
      res_c       <= 1'b0;
      res_v       <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      err         <= 1'b0;
      stk_pop     <= 1'b0;
      stk_push    <= 1'b0;
      stk_data_in <= '0;
      z_flag      <= 1'b0;
      s_flag      <= 1'b0;
      c_flag      <= 1'b0;
      v_flag      <= 1'b0;
    end else begin
      // NOTE: non-blocking so every register samples the pre-edge values computed above.
      state       <= state_n;
      op_q        <= op_n;
      op1         <= op1_n;
      op2         <= op2_n;
      res         <= res_n;
      res_c       <= res_c_n;
      res_v       <= res_v_n;
      busy        <= busy_n;
      done        <= done_n;
      err         <= err_n;
      stk_pop     <= pop_n;
      stk_push    <= push_n;
      stk_data_in <= data_in_n;
      z_flag      <= z_n;
      s_flag      <= s_n;
      c_flag      <= c_n;
      v_flag      <= v_n;
    end
  end

endmodule

// File: tb/tb_stack_alu_unit.sv
// Directed bench for stack_alu_unit: a behavioural LIFO model drives the stack
// side and every request is checked against hand-computed results.
module tb_stack_alu_unit;

  logic       clk = 1'b0;
  logic       rstn;
  logic       start;
  logic [2:0] opcode;
  logic       busy, done, err, z_flag, s_flag, c_flag, v_flag;
  logic [3:0] stk_count;
  logic [7:0] stk_data_out;
  logic       stk_pop, stk_push;
  logic [7:0] stk_data_in;

  logic [7:0] mem [0:15];
  int         sp;
  int         pops, pushes;
  logic [7:0] last_push;
  int         total  = 0;
  int         passed = 0;

  stack_alu_unit #(.DATA_LEN(8), .CNT_W(4)) dut (
    .clk(clk), .rstn(rstn), .start(start), .opcode(opcode),
    .busy(busy), .done(done), .err(err),
    .z_flag(z_flag), .s_flag(s_flag), .c_flag(c_flag), .v_flag(v_flag),
    .stk_count(stk_count), .stk_data_out(stk_data_out),
    .stk_pop(stk_pop), .stk_push(stk_push), .stk_data_in(stk_data_in)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    else passed++;
  endtask

  // One clock: strobes sampled before the edge, stack model updated just after it.
  task automatic tick();
    logic       p, q;
    logic [7:0] d;
    p = stk_pop;
    q = stk_push;
    d = stk_data_in;
    @(posedge clk);
    #1;
    if (p && sp > 0) begin
      stk_data_out = mem[sp-1];
      sp--;
      pops++;
    end
    if (q && sp < 16) begin
      mem[sp] = d;
      sp++;
      pushes++;
      last_push = d;
    end
    stk_count = sp[3:0];
  endtask

  task automatic run_op(input string tag, input logic [2:0] op, input logic [7:0] top,
                        input logic [7:0] nxt, input int cnt, input logic [7:0] exp_res,
                        input logic [3:0] exp_flags, input int exp_lat, input logic exp_err);
    int lat;
    int arity;
    arity = (op >= 3'd5) ? 1 : 2;
    sp = 0;
    if (cnt >= 2) begin
      mem[0] = nxt;
      mem[1] = top;
      sp = 2;
    end else if (cnt == 1) begin
      mem[0] = top;
      sp = 1;
    end
    stk_count = sp[3:0];
    pops = 0;
    pushes = 0;
    last_push = 8'h00;
    opcode = op;
    start = 1'b1;
    tick();
    start = 1'b0;
    lat = 0;
    while (!done && lat < 20) begin
      tick();
      lat++;
    end
    check({tag, "_lat"}, lat, exp_lat);
    check({tag, "_err"}, err, exp_err);
    check({tag, "_flags"}, {z_flag, s_flag, c_flag, v_flag}, exp_flags);
    check({tag, "_busy"}, busy, 1'b1);
    if (exp_err) begin
      check({tag, "_pops"}, pops, 0);
      check({tag, "_pushes"}, pushes, 0);
    end else begin
      check({tag, "_pops"}, pops, arity);
      check({tag, "_pushes"}, pushes, 1);
      check({tag, "_res"}, last_push, exp_res);
      check({tag, "_sp"}, sp, cnt - arity + 1);
    end
    tick();
    check({tag, "_idle"}, {busy, done}, 2'b00);
  endtask

  initial begin
    int accepts;
    logic prev_busy;

    rstn = 1'b0;
    start = 1'b0;
    opcode = 3'd0;
    sp = 0;
    stk_count = 4'd0;
    stk_data_out = 8'h00;
    pops = 0;
    pushes = 0;
    #3;
    check("reset_ctl", {busy, done, err, stk_pop, stk_push}, 5'b0);
    check("reset_flags", {z_flag, s_flag, c_flag, v_flag}, 4'b0);
    check("reset_data", stk_data_in, 8'h00);
    @(posedge clk);
    #1;
    rstn = 1'b1;

    //      tag     op    top    next   cnt res    ZSCV     lat err
    run_op("add",   3'd0, 8'h03, 8'h05, 2, 8'h08, 4'b0000, 6, 1'b0);
    run_op("addov", 3'd0, 8'h01, 8'h7F, 2, 8'h80, 4'b0101, 6, 1'b0);
    run_op("sub",   3'd1, 8'h05, 8'h03, 2, 8'hFE, 4'b0110, 6, 1'b0);
    run_op("subuf", 3'd1, 8'h09, 8'h00, 1, 8'h00, 4'b0110, 0, 1'b1);
    run_op("neg",   3'd5, 8'h80, 8'h00, 1, 8'h80, 4'b0111, 4, 1'b0);
    run_op("shl",   3'd6, 8'hC0, 8'h00, 1, 8'h80, 4'b0110, 4, 1'b0);
    run_op("sar",   3'd7, 8'h81, 8'h00, 1, 8'hC0, 4'b0110, 4, 1'b0);
    run_op("and",   3'd2, 8'h3C, 8'hF0, 2, 8'h30, 4'b0000, 6, 1'b0);
    run_op("or",    3'd3, 8'h0F, 8'h30, 2, 8'h3F, 4'b0000, 6, 1'b0);
    run_op("xor",   3'd4, 8'h5A, 8'h5A, 2, 8'h00, 4'b1000, 6, 1'b0);
    run_op("neguf", 3'd5, 8'h00, 8'h00, 0, 8'h00, 4'b1000, 0, 1'b1);

    // start held high: NEG repeats every 6 edges, only from IDLE.
    mem[0] = 8'h01;
    mem[1] = 8'h02;
    mem[2] = 8'h03;
    sp = 3;
    stk_count = 4'd3;
    pops = 0;
    pushes = 0;
    accepts = 0;
    prev_busy = busy;
    opcode = 3'd5;
    start = 1'b1;
    for (int i = 0; i < 18; i++) begin
      tick();
      if (busy && !prev_busy) accepts++;
      prev_busy = busy;
    end
    start = 1'b0;
    check("b2b_accepts", accepts, 3);
    check("b2b_pops", pops, 3);
    check("b2b_pushes", pushes, 3);
    check("b2b_top", mem[sp-1], 8'hFD);
    check("b2b_sp", sp, 3);
    check("b2b_idle", busy, 1'b0);

    // Reset while in CAP2 aborts the request with no push.
    mem[0] = 8'h03;
    mem[1] = 8'h05;
    sp = 2;
    stk_count = 4'd2;
    pops = 0;
    pushes = 0;
    opcode = 3'd1;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    tick();
    check("abort_pops", pops, 2);
    #2;
    rstn = 1'b0;
    #1;
    check("abort_ctl", {busy, done, err, stk_pop, stk_push}, 5'b0);
    check("abort_flags", {z_flag, s_flag, c_flag, v_flag}, 4'b0);
    check("abort_data", stk_data_in, 8'h00);
    tick();
    tick();
    tick();
    check("abort_nopush", pushes, 0);
    rstn = 1'b1;
    run_op("post",  3'd0, 8'h80, 8'h80, 2, 8'h00, 4'b1011, 6, 1'b0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
